// File: rtl/distance_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : distance_conditioner
// Description : Conditions raw distance samples before they reach the FM tone
//               generator. Each sample is clamped to the LUT range. The last
//               2**AVG_LOG2 clamped samples are box-car averaged, and the output
//               is slew-limited so distance steps glide in frequency.
// Ports       : clk            - system clock
//               reset_n        - asynchronous, active-low reset
//               enable         - global clock enable; all state holds when low
//               sample_valid   - one-cycle strobe qualifying sample
//               sample         - raw distance sample
//               tick           - one-cycle output update strobe (PWM zero)
//               distance       - conditioned distance to the FM DAC
//               distance_valid - high once the average buffer has filled
//               at_target      - registered (distance == avg)
// Revision    : 1.0 - initial release
// ============================================================================
module distance_conditioner #(
  parameter int WIDTH     = 13,
  parameter int AVG_LOG2  = 4,
  parameter int MAX_DIST  = 2000,
  parameter int SLEW_STEP = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  input  logic             tick,
  output logic [WIDTH-1:0] distance,
  output logic             distance_valid,
  output logic             at_target
);

  localparam int                c_depth    = 1 << AVG_LOG2;
  localparam int                c_sum_w    = WIDTH + AVG_LOG2;
  localparam logic [WIDTH-1:0]  c_max      = WIDTH'(MAX_DIST);
  localparam logic [WIDTH-1:0]  c_step     = WIDTH'(SLEW_STEP);
  localparam logic [AVG_LOG2:0] c_full     = (AVG_LOG2 + 1)'(c_depth);
  localparam logic [AVG_LOG2:0] c_fill_one = (AVG_LOG2 + 1)'(1);
  localparam logic [AVG_LOG2-1:0] c_ptr_one = AVG_LOG2'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]    r_buf_mem [c_depth];
  logic [c_sum_w-1:0]  r_sum;
  logic [AVG_LOG2-1:0] r_wr_ptr;
  logic [AVG_LOG2:0]   r_fill_cnt;
  logic [WIDTH-1:0]    r_avg;
  logic [WIDTH-1:0]    r_distance;
  logic                r_at_target;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic               w_accept;
  logic               w_do_tick;
  logic [WIDTH-1:0]   w_clamped;
  logic [WIDTH-1:0]   w_oldest;
  logic [c_sum_w-1:0] w_sum_next;
  logic [WIDTH-1:0]   w_gap_up;
  logic [WIDTH-1:0]   w_gap_dn;
  logic [WIDTH-1:0]   w_step_up;
  logic [WIDTH-1:0]   w_step_dn;
  logic [WIDTH-1:0]   w_dist_next;

  assign w_accept  = enable & sample_valid;
  assign w_do_tick = enable & tick;

  // Clamp ahead of the buffer so the average can never exceed MAX_DIST.
  assign w_clamped = (sample > c_max) ? c_max : sample;

  // The slot about to be overwritten holds the oldest sample in the window
  // (or zero while filling), so a running sum replaces a full adder tree.
  assign w_oldest   = r_buf_mem[r_wr_ptr];
  assign w_sum_next = r_sum - c_sum_w'(w_oldest) + c_sum_w'(w_clamped);

  // Gaps are only meaningful in the direction selected below, so the
  // unsigned wrap in the other direction is harmless.
  assign w_gap_up  = r_avg - r_distance;
  assign w_gap_dn  = r_distance - r_avg;
  assign w_step_up = (w_gap_up > c_step) ? c_step : w_gap_up;
  assign w_step_dn = (w_gap_dn > c_step) ? c_step : w_gap_dn;

  // Limiting the step to the remaining gap prevents overshoot; because avg is
  // bounded by MAX_DIST, distance stays in [0, MAX_DIST] as well.
  always_comb begin
    w_dist_next = r_distance;
    if (r_avg > r_distance) begin
      w_dist_next = r_distance + w_step_up;
    end else if (r_avg < r_distance) begin
      w_dist_next = r_distance - w_step_dn;
    end
  end

  // --------------------------------------------------------------------------
  // Sample buffer (circular, wr_ptr wraps naturally at 2**AVG_LOG2)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < c_depth; i++) begin
        r_buf_mem[i] <= '0;
      end
    end else if (w_accept) begin
      r_buf_mem[r_wr_ptr] <= w_clamped;
    end
  end

  // --------------------------------------------------------------------------
  // Averager, fill counter and slew limiter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum       <= '0;
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_avg       <= '0;
      r_distance  <= '0;
      r_at_target <= 1'b1;
    end else if (enable) begin
      if (sample_valid) begin
        r_sum    <= w_sum_next;
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
        if (r_fill_cnt != c_full) begin
          r_fill_cnt <= r_fill_cnt + c_fill_one;
        end
      end

      // Average is taken from the sum register, giving sample -> sum -> avg
      // a two-cycle latency. Unfilled slots contribute zero.
      r_avg <= r_sum[c_sum_w-1:AVG_LOG2];

      // The slew step and the target flag both look at the pre-update avg,
      // so a tick coincident with an avg change uses the old value.
      if (w_do_tick) begin
        r_distance <= w_dist_next;
      end
      r_at_target <= (r_distance == r_avg);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign distance       = r_distance;
  assign distance_valid = (r_fill_cnt == c_full);
  assign at_target      = r_at_target;

endmodule
`default_nettype wire
